ipml_reg_fifo_v2_0_depth_fifo: RTL and testbench



---
 rtl/ipml_reg_fifo_pkg.sv | 26 ++
 rtl/ipml_reg_fifo_v2_0_ptr.sv | 28 ++
 rtl/ipml_reg_fifo_v2_0_depth_fifo.sv | 101 ++++++++++
 tb/tb_ipml_reg_fifo_v2_0_depth_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ipml_reg_fifo_pkg.sv
// ipml_reg_fifo_pkg
// Shared helpers for the register-based FIFO family:
//   clog2        - ceil(log2(value)), usable in parameter/port declarations
//   is_pow2      - true when value is a positive power of two
//   params_legal - legality of a DEPTH / AF_THRESH combination
package ipml_reg_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int depth, input int af_thresh);
    return is_pow2(depth) && (depth >= 2) && (depth <= 64) &&
           (af_thresh >= 1) && (af_thresh <= depth);
  endfunction

endpackage

// File: rtl/ipml_reg_fifo_v2_0_ptr.sv
// ipml_reg_fifo_v2_0_ptr
// Wrapping FIFO pointer. Counts modulo 2**AW, which equals the FIFO depth.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, pointer to 0
//   clr  - synchronous clear (flush), pointer to 0
//   inc  - advance pointer by one
//   ptr  - current pointer value
module ipml_reg_fifo_v2_0_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  // Natural binary overflow gives the modulo-DEPTH wrap for free.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/ipml_reg_fifo_v2_0_depth_fifo.sv
// ipml_reg_fifo_v2_0_depth_fifo
// Register-based ready/valid FIFO with first-word fall-through output,
// occupancy level, almost-full flag and synchronous flush.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   flush           - synchronous clear of contents (storage itself kept)
//   data_in_valid   - upstream valid
//   data_in         - upstream data
//   data_in_ready   - FIFO accepts a word this cycle
//   data_out_ready  - downstream ready
//   data_out        - head-of-FIFO word
//   data_out_valid  - FIFO non-empty
//   level           - current occupancy, 0..DEPTH
//   almost_full     - level >= AF_THRESH
module ipml_reg_fifo_v2_0_depth_fifo
  import ipml_reg_fifo_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  data_in_valid,
  input  logic [W-1:0]          data_in,
  output logic                  data_in_ready,
  input  logic                  data_out_ready,
  output logic [W-1:0]          data_out,
  output logic                  data_out_valid,
  output logic [clog2(DEPTH):0] level,
  output logic                  almost_full
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);

  if (!params_legal(DEPTH, AF_THRESH)) begin : g_param_error
    $error("ipml_reg_fifo_v2_0_depth_fifo: DEPTH must be a power of two in 2..64 and AF_THRESH in 1..DEPTH");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] count;
  logic          write;
  logic          read;

  // Ready/valid are gated by flush and rst so no handshake can complete in
  // a cycle whose effects are about to be discarded.
  assign data_in_ready  = (count != DEPTH_L) && !flush && !rst;
  assign data_out_valid = (count != '0) && !flush && !rst;
  assign write          = data_in_valid && data_in_ready;
  assign read           = data_out_valid && data_out_ready;

  assign data_out    = mem[rptr];
  assign level       = count;
  assign almost_full = (count >= AF_L);

  ipml_reg_fifo_v2_0_ptr #(.AW(AW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (write),
    .ptr (wptr)
  );

  ipml_reg_fifo_v2_0_ptr #(.AW(AW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (read),
    .ptr (rptr)
  );

  // Storage is cleared only by rst; flush leaves stale words behind, which
  // are unreachable because the pointers and count restart from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write) begin
      mem[wptr] <= data_in;
    end
  end

  // Simultaneous write and read leave the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (write && !read) begin
      count <= count + LW'(1);
    end else if (read && !write) begin
      count <= count - LW'(1);
    end
  end

endmodule

// File: tb/tb_ipml_reg_fifo_v2_0_depth_fifo.sv
// tb_ipml_reg_fifo_v2_0_depth_fifo
// Instance A (DEPTH=4, AF_THRESH=3) runs directed vectors with literal
// expectations; instance B (DEPTH=8, AF_THRESH=5) runs random traffic.
// Each instance has a queue model compared against the DUT every cycle.
module tb_ipml_reg_fifo_v2_0_depth_fifo;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance A ----------------
  logic         a_rst = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [W-1:0] a_in = '0;
  logic         a_in_ready, a_out_valid, a_af;
  logic [W-1:0] a_out;
  logic [2:0]   a_level;
  bit           a_on = 1'b0, a_done = 1'b0;

  ipml_reg_fifo_v2_0_depth_fifo #(.W(W), .DEPTH(4), .AF_THRESH(3)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .data_in_valid(a_in_valid), .data_in(a_in), .data_in_ready(a_in_ready),
    .data_out_ready(a_out_ready), .data_out(a_out), .data_out_valid(a_out_valid),
    .level(a_level), .almost_full(a_af)
  );

  // ---------------- instance B ----------------
  logic         b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [W-1:0] b_in = '0;
  logic         b_in_ready, b_out_valid, b_af;
  logic [W-1:0] b_out;
  logic [3:0]   b_level;
  bit           b_on = 1'b0, b_done = 1'b0;

  ipml_reg_fifo_v2_0_depth_fifo #(.W(W), .DEPTH(8), .AF_THRESH(5)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .data_in_valid(b_in_valid), .data_in(b_in), .data_in_ready(b_in_ready),
    .data_out_ready(b_out_ready), .data_out(b_out), .data_out_valid(b_out_valid),
    .level(b_level), .almost_full(b_af)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- queue models ----------------
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  always @(posedge clk) begin : model_a
    bit mr, mv;
    mr = (qa.size() < 4) && !a_flush && !a_rst;
    mv = (qa.size() > 0) && !a_flush && !a_rst;
    if (a_rst || a_flush) qa.delete();
    else begin
      if (mv && a_out_ready) void'(qa.pop_front());
      if (mr && a_in_valid) qa.push_back(a_in);
    end
  end

  always @(posedge clk) begin : model_b
    bit mr, mv;
    mr = (qb.size() < 8) && !b_flush && !b_rst;
    mv = (qb.size() > 0) && !b_flush && !b_rst;
    if (b_rst || b_flush) qb.delete();
    else begin
      if (mv && b_out_ready) void'(qb.pop_front());
      if (mr && b_in_valid) qb.push_back(b_in);
    end
  end

  always @(negedge clk) begin : cmp_a
    bit er, ev;
    if (a_on) begin
      er = (qa.size() < 4) && !a_flush && !a_rst;
      ev = (qa.size() > 0) && !a_flush && !a_rst;
      checkOutput("a_ready", 32'(a_in_ready), 32'(er));
      checkOutput("a_valid", 32'(a_out_valid), 32'(ev));
      checkOutput("a_level", 32'(a_level), 32'(qa.size()));
      checkOutput("a_af", 32'(a_af), 32'(qa.size() >= 3));
      if (ev) checkOutput("a_data", 32'(a_out), 32'(qa[0]));
    end
  end

  always @(negedge clk) begin : cmp_b
    bit er, ev;
    if (b_on) begin
      er = (qb.size() < 8) && !b_flush && !b_rst;
      ev = (qb.size() > 0) && !b_flush && !b_rst;
      checkOutput("b_ready", 32'(b_in_ready), 32'(er));
      checkOutput("b_valid", 32'(b_out_valid), 32'(ev));
      checkOutput("b_level", 32'(b_level), 32'(qb.size()));
      checkOutput("b_af", 32'(b_af), 32'(qb.size() >= 5));
      if (ev) checkOutput("b_data", 32'(b_out), 32'(qb[0]));
    end
  end

  task automatic applyStimulus(input logic rst, input logic flush, input logic valid,
                               input logic [W-1:0] data, input logic out_ready);
    @(posedge clk);
    #1;
    a_rst       = rst;
    a_flush     = flush;
    a_in_valid  = valid;
    a_in        = data;
    a_out_ready = out_ready;
  endtask

  // ---------------- directed sequence on A ----------------
  initial begin : directed
    logic [W-1:0] drain_exp [4];
    drain_exp = '{8'h22, 8'h33, 8'h44, 8'h55};
    a_rst = 1'b1; a_in_valid = 1'b1; a_in = 8'hAA;
    @(posedge clk);
    a_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_ready", 32'(a_in_ready), 0);
      checkOutput("rst_valid", 32'(a_out_valid), 0);
    end
    applyStimulus(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(a_in_ready), 1);
    checkOutput("post_rst_level", 32'(a_level), 0);
    checkOutput("post_rst_data", 32'(a_out), 0);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 1, W'(8'h11 * (k + 1)), 0);
      @(negedge clk);
      checkOutput("fill_level", 32'(a_level), 32'(k));
      checkOutput("fill_af", 32'(a_af), 32'(k >= 3));
      checkOutput("fill_ready", 32'(a_in_ready), 1);
    end
    applyStimulus(0, 0, 1, 8'h55, 0);
    @(negedge clk);
    checkOutput("full_level", 32'(a_level), 4);
    checkOutput("full_ready", 32'(a_in_ready), 0);
    checkOutput("full_af", 32'(a_af), 1);
    @(negedge clk);
    checkOutput("held_level", 32'(a_level), 4);

    applyStimulus(0, 0, 1, 8'h55, 1);
    @(negedge clk);
    checkOutput("fullrw_ready", 32'(a_in_ready), 0);
    checkOutput("fullrw_data", 32'(a_out), 32'h11);
    applyStimulus(0, 0, 1, 8'h55, 0);
    @(negedge clk);
    checkOutput("fullrw_level", 32'(a_level), 3);
    checkOutput("fullrw_ready2", 32'(a_in_ready), 1);
    applyStimulus(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checkOutput("refill_level", 32'(a_level), 4);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 8'h00, 1);
      @(negedge clk);
      checkOutput("drain_valid", 32'(a_out_valid), 1);
      checkOutput("drain_data", 32'(a_out), 32'(drain_exp[k]));
    end
    applyStimulus(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checkOutput("empty_valid", 32'(a_out_valid), 0);
    checkOutput("empty_level", 32'(a_level), 0);

    applyStimulus(0, 0, 1, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'h01, 0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 0, 1, W'(i + 2), 1);
      @(negedge clk);
      checkOutput("stream_level", 32'(a_level), 2);
      checkOutput("stream_hs", 32'(a_in_ready && a_out_valid), 1);
    end

    applyStimulus(0, 0, 1, 8'h77, 0);
    @(negedge clk);
    checkOutput("pre_flush_level", 32'(a_level), 2);
    applyStimulus(0, 1, 1, 8'h88, 1);
    @(negedge clk);
    checkOutput("flush_level", 32'(a_level), 3);
    checkOutput("flush_ready", 32'(a_in_ready), 0);
    checkOutput("flush_valid", 32'(a_out_valid), 0);
    applyStimulus(0, 0, 1, 8'h99, 0);
    @(negedge clk);
    checkOutput("post_flush_level", 32'(a_level), 0);
    checkOutput("post_flush_valid", 32'(a_out_valid), 0);
    checkOutput("post_flush_ready", 32'(a_in_ready), 1);
    applyStimulus(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checkOutput("after_flush_data", 32'(a_out), 32'h99);
    checkOutput("after_flush_level", 32'(a_level), 1);

    applyStimulus(1, 0, 1, 8'hAB, 1);
    @(negedge clk);
    checkOutput("midrst_ready", 32'(a_in_ready), 0);
    checkOutput("midrst_valid", 32'(a_out_valid), 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    @(negedge clk);
    checkOutput("midrst_level", 32'(a_level), 0);
    checkOutput("midrst_data", 32'(a_out), 0);
    a_done = 1'b1;
  end

  // ---------------- random traffic on B ----------------
  initial begin : random_b
    b_rst = 1'b1;
    @(posedge clk);
    b_on = 1'b1;
    @(posedge clk);
    #1;
    b_rst = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_in        = W'($urandom);
      b_flush     = ($urandom_range(0, 199) == 0);
    end
    b_done = 1'b1;
  end

  initial begin : finisher
    int cycles;
    cycles = 0;
    while (!(a_done && b_done) && cycles < 20000) begin
      @(posedge clk);
      cycles++;
    end
    if (!(a_done && b_done)) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL timeout: got not-done, expected done at %0t", $time);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
